// File: rtl/qos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qos_pkg
//  Description : Shared defaults and FSM encoding for the QoS read scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package qos_pkg;

  localparam int QOS_N_BUF     = 4;
  localparam int QOS_DATA_W    = 2;
  localparam int QOS_CNT_W     = 3;
  localparam int QOS_SCNT_W    = 7;
  localparam int QOS_RD_LAT    = 2;
  localparam int QOS_BUF_DEPTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/qos_pick.sv
`default_nettype none
// ============================================================================
//  Module      : qos_pick
//  Description : Combinational max-occupancy arbiter; ties resolve to the
//                highest buffer index.
//  Revision    : 1.0 - initial release
// ============================================================================
module qos_pick
  import qos_pkg::*;
#(
  parameter int N_BUF = QOS_N_BUF,
  parameter int CNT_W = QOS_CNT_W,
  parameter int SEL_W = 2
) (
  input  logic [N_BUF*CNT_W-1:0] data_count_i,
  output logic [SEL_W-1:0]       winner_o,
  output logic                   any_pend_o
);

  logic [CNT_W-1:0] w_best;

  // Ascending scan with >= so a later (higher) index wins any tie
  always_comb begin
    w_best     = '0;
    winner_o   = '0;
    any_pend_o = 1'b0;
    for (int i = 0; i < N_BUF; i++) begin
      if (data_count_i[i*CNT_W +: CNT_W] >= w_best) begin
        w_best   = data_count_i[i*CNT_W +: CNT_W];
        winner_o = SEL_W'(i);
      end
      if (data_count_i[i*CNT_W +: CNT_W] != '0) begin
        any_pend_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qos_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : qos_scheduler
//  Description : Read-side QoS scheduler. Arms one buffer's rd per 3 s slot,
//                captures the dequeued packet RD_LAT cycles after the slot
//                edge and emits it on the tx interface with statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module qos_scheduler
  import qos_pkg::*;
#(
  parameter int N_BUF  = QOS_N_BUF,
  parameter int DATA_W = QOS_DATA_W,
  parameter int CNT_W  = QOS_CNT_W,
  parameter int RD_LAT = QOS_RD_LAT,
  parameter int SCNT_W = QOS_SCNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk3sn_i,
  input  logic [N_BUF*CNT_W-1:0]  data_count_i,
  input  logic [N_BUF*DATA_W-1:0] buf_out_i,
  input  logic [N_BUF-1:0]        out_en_i,
  output logic [N_BUF-1:0]        rd_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic [1:0]              tx_src_o,
  output logic                    tx_valid_o,
  output logic [N_BUF*SCNT_W-1:0] served_cnt_o,
  output logic [SCNT_W-1:0]       miss_cnt_o
);

  localparam int SEL_W = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e              state_q,   state_d;
  logic [SEL_W-1:0]    sel_q,     sel_d;
  logic [N_BUF-1:0]    rd_q,      rd_d;
  logic [LAT_W-1:0]    lat_q,     lat_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [1:0]          tx_src_q,  tx_src_d;
  logic                tx_valid_q, tx_valid_d;
  logic [SCNT_W-1:0]   served_q [N_BUF];
  logic [SCNT_W-1:0]   served_d [N_BUF];
  logic [SCNT_W-1:0]   miss_q,    miss_d;
  logic                prev_tick_q;

  logic                w_tick;
  logic [SEL_W-1:0]    w_winner;
  logic                w_any_pend;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_en;

  qos_pick #(
    .N_BUF (N_BUF),
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_pick (
    .data_count_i (data_count_i),
    .winner_o     (w_winner),
    .any_pend_o   (w_any_pend)
  );

  assign w_tick     = clk3sn_i & ~prev_tick_q;
  assign w_sel_data = buf_out_i[sel_q*DATA_W +: DATA_W];
  assign w_sel_en   = out_en_i[sel_q];

  // Slot FSM: arm in IDLE, wait for the slot edge, capture after RD_LAT
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    lat_d      = lat_q;
    tx_data_d  = tx_data_q;
    tx_src_d   = tx_src_q;
    tx_valid_d = 1'b0;
    served_d   = served_q;
    miss_d     = miss_q;
    case (state_q)
      ST_IDLE: begin
        // A tick seen here is ignored: rd is only just being raised
        if (w_any_pend) begin
          sel_d   = w_winner;
          rd_d    = N_BUF'(1) << w_winner;
          state_d = ST_ARMED;
        end else begin
          rd_d = '0;
        end
      end
      ST_ARMED: begin
        if (w_tick) begin
          rd_d    = '0;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rd_d = '0;
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          if (w_sel_en) begin
            tx_data_d       = w_sel_data;
            tx_src_d        = 2'(sel_q);
            tx_valid_d      = 1'b1;
            served_d[sel_q] = served_q[sel_q] + SCNT_W'(1);
          end else begin
            miss_d = miss_q + SCNT_W'(1);
          end
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        rd_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, capture and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rd_q        <= '0;
      lat_q       <= '0;
      tx_data_q   <= '0;
      tx_src_q    <= '0;
      tx_valid_q  <= 1'b0;
      miss_q      <= '0;
      prev_tick_q <= 1'b0;
      for (int i = 0; i < N_BUF; i++) begin
        served_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      lat_q       <= lat_d;
      tx_data_q   <= tx_data_d;
      tx_src_q    <= tx_src_d;
      tx_valid_q  <= tx_valid_d;
      miss_q      <= miss_d;
      prev_tick_q <= clk3sn_i;
      for (int i = 0; i < N_BUF; i++) begin
        served_q[i] <= served_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < N_BUF; g++) begin : g_served
      assign served_cnt_o[g*SCNT_W +: SCNT_W] = served_q[g];
    end
  endgenerate

  assign rd_o       = rd_q;
  assign tx_data_o  = tx_data_q;
  assign tx_src_o   = tx_src_q;
  assign tx_valid_o = tx_valid_q;
  assign miss_cnt_o = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_qos_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qos_scheduler
//  Description : Directed self-checking bench for qos_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qos_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk3sn = 1'b0;
  logic [11:0] data_count = '0;
  logic [7:0]  buf_out = '0;
  logic [3:0]  out_en = '0;
  logic [3:0]  rd;
  logic [1:0]  tx_data;
  logic [1:0]  tx_src;
  logic        tx_valid;
  logic [27:0] served_cnt;
  logic [6:0]  miss_cnt;

  int checks = 0;
  int errors = 0;
  int txv_cnt = 0;

  qos_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .clk3sn_i     (clk3sn),
    .data_count_i (data_count),
    .buf_out_i    (buf_out),
    .out_en_i     (out_en),
    .rd_o         (rd),
    .tx_data_o    (tx_data),
    .tx_src_o     (tx_src),
    .tx_valid_o   (tx_valid),
    .served_cnt_o (served_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Count transmitted pulses away from the active edge
  always @(negedge clk) begin
    if (tx_valid === 1'b1) txv_cnt++;
  end

  function automatic logic [6:0] served(input int i);
    logic [27:0] v;
    v = served_cnt;
    return v[i*7 +: 7];
  endfunction

  // counts packed {b3,b2,b1,b0}
  function automatic logic [11:0] pack_cnt(input int b0, input int b1, input int b2, input int b3);
    return {3'(b3), 3'(b2), 3'(b1), 3'(b0)};
  endfunction

  task automatic do_reset(input logic [11:0] cnt, input logic c3);
    @(negedge clk);
    rst = 1'b1; data_count = cnt; clk3sn = c3; out_en = '0; buf_out = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One slot: clk3sn rises at N0; buffer presents data only in the cycle the
  // scheduler should sample it (RD_LAT=2 after the detected rise); returns at
  // the negedge where the resulting tx_valid pulse is visible.
  task automatic slot(input logic [3:0] en, input logic [7:0] bo);
    @(negedge clk); clk3sn = 1'b1;
    @(negedge clk);
    @(negedge clk); out_en = en; buf_out = bo;
    @(negedge clk); out_en = '0; buf_out = '0; clk3sn = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; data_count = pack_cnt(1, 2, 3, 4);
    @(negedge clk);
    checks++;
    if ({rd, tx_data, tx_src, tx_valid, served_cnt, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b txd=%b src=%0d v=%b served=%h miss=%0d, want all 0",
               rd, tx_data, tx_src, tx_valid, served_cnt, miss_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_empty;
    int t0;
    do_reset('0, 1'b0);
    t0 = txv_cnt;
    for (int k = 0; k < 3; k++) begin
      slot(4'b1111, 8'hFF);
      checks++;
      if (rd !== 4'b0000) begin
        errors++; $display("FAIL empty_rd: got %b want 0000", rd);
      end
    end
    checks++;
    if (txv_cnt != t0 || miss_cnt !== 7'd0) begin
      errors++; $display("FAIL empty_tx: got tx=%0d miss=%0d want 0 0", txv_cnt - t0, miss_cnt);
    end
  endtask

  task automatic test_serve;
    do_reset(pack_cnt(2, 5, 1, 0), 1'b0);
    @(negedge clk);
    checks++;
    if (rd !== 4'b0010) begin
      errors++; $display("FAIL serve_rd: got %b want 0010", rd);
    end
    slot(4'b0010, 8'b00_00_10_00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 2'b10 || tx_src !== 2'd1) begin
      errors++; $display("FAIL serve_tx: got v=%b d=%b s=%0d want 1 10 1", tx_valid, tx_data, tx_src);
    end
    checks++;
    if (served(1) !== 7'd1 || served(0) !== 7'd0 || miss_cnt !== 7'd0) begin
      errors++; $display("FAIL serve_cnt: got s1=%0d s0=%0d miss=%0d want 1 0 0", served(1), served(0), miss_cnt);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 2'b10 || tx_src !== 2'd1) begin
      errors++; $display("FAIL serve_hold: got v=%b d=%b s=%0d want 0 10 1", tx_valid, tx_data, tx_src);
    end
  endtask

  task automatic test_tie;
    do_reset(pack_cnt(0, 3, 0, 3), 1'b0);
    @(negedge clk);
    checks++;
    if (rd !== 4'b1000) begin
      errors++; $display("FAIL tie_rd: got %b want 1000", rd);
    end
    slot(4'b1000, 8'b01_00_00_00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 2'b01 || tx_src !== 2'd3 || served(3) !== 7'd1) begin
      errors++; $display("FAIL tie_tx: got v=%b d=%b s=%0d s3=%0d want 1 01 3 1", tx_valid, tx_data, tx_src, served(3));
    end
  endtask

  task automatic test_miss;
    int t0;
    do_reset(pack_cnt(0, 0, 4, 0), 1'b0);
    @(negedge clk);
    t0 = txv_cnt;
    slot(4'b0000, 8'hFF);
    checks++;
    if (tx_valid !== 1'b0 || miss_cnt !== 7'd1 || served(2) !== 7'd0) begin
      errors++; $display("FAIL miss_cnt: got v=%b miss=%0d s2=%0d want 0 1 0", tx_valid, miss_cnt, served(2));
    end
    checks++;
    if (rd !== 4'b0000) begin
      errors++; $display("FAIL miss_rd_clear: got %b want 0000", rd);
    end
    @(negedge clk);
    checks++;
    if (rd !== 4'b0100 || txv_cnt != t0) begin
      errors++; $display("FAIL miss_rearm: got rd=%b tx=%0d want 0100 0", rd, txv_cnt - t0);
    end
  endtask

  task automatic test_arm_tick;
    int t0;
    do_reset('0, 1'b0);
    @(negedge clk);
    t0 = txv_cnt;
    data_count = pack_cnt(1, 0, 0, 0); clk3sn = 1'b1;
    @(negedge clk); clk3sn = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rd !== 4'b0001 || txv_cnt != t0 || miss_cnt !== 7'd0) begin
      errors++; $display("FAIL arm_tick: got rd=%b tx=%0d miss=%0d want 0001 0 0", rd, txv_cnt - t0, miss_cnt);
    end
  endtask

  task automatic test_reset_wait;
    int t0;
    do_reset(pack_cnt(1, 0, 0, 0), 1'b0);
    @(negedge clk);
    slot(4'b0001, 8'b00_00_00_01);
    checks++;
    if (served(0) !== 7'd1) begin
      errors++; $display("FAIL rstwait_pre: got s0=%0d want 1", served(0));
    end
    @(negedge clk); clk3sn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rd !== 4'b0000 || tx_valid !== 1'b0 || served_cnt !== '0 || miss_cnt !== 7'd0 || tx_data !== 2'b00) begin
      errors++; $display("FAIL rstwait_async: got rd=%b v=%b served=%h miss=%0d d=%b want all 0",
                         rd, tx_valid, served_cnt, miss_cnt, tx_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t0 = txv_cnt;
    repeat (4) @(negedge clk);
    clk3sn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rd !== 4'b0001 || txv_cnt != t0 || miss_cnt !== 7'd0) begin
      errors++; $display("FAIL rstwait_release: got rd=%b tx=%0d miss=%0d want 0001 0 0", rd, txv_cnt - t0, miss_cnt);
    end
    slot(4'b0001, 8'b00_00_00_11);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 2'b11 || tx_src !== 2'd0 || served(0) !== 7'd1) begin
      errors++; $display("FAIL rstwait_serve: got v=%b d=%b s=%0d s0=%0d want 1 11 0 1", tx_valid, tx_data, tx_src, served(0));
    end
  endtask

  task automatic test_wrap;
    int t0;
    do_reset(pack_cnt(0, 0, 5, 0), 1'b0);
    @(negedge clk);
    t0 = txv_cnt;
    for (int k = 0; k < 127; k++) slot(4'b0100, 8'b00_11_00_00);
    checks++;
    if (served(2) !== 7'd127) begin
      errors++; $display("FAIL wrap_127: got %0d want 127", served(2));
    end
    slot(4'b0100, 8'b00_11_00_00);
    checks++;
    if (served(2) !== 7'd0 || miss_cnt !== 7'd0) begin
      errors++; $display("FAIL wrap_0: got s2=%0d miss=%0d want 0 0", served(2), miss_cnt);
    end
    @(negedge clk);
    checks++;
    if (txv_cnt - t0 != 128) begin
      errors++; $display("FAIL wrap_txcount: got %0d want 128", txv_cnt - t0);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_serve();
    test_tie();
    test_miss();
    test_arm_tick();
    test_reset_wait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
